// File: rtl/ifid_reg.sv
// ifid_reg: fetch/decode pipeline register with stall, flush, AdEL detection and perf counters
module ifid_reg #(
    parameter logic [31:0] IM_BASE  = 32'h00003000,
    parameter int          IM_WORDS = 4096,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc4_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        adel_d,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);
    logic [32:0] im_end;
    logic        adel_f;
    assign im_end = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
    assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= im_end);
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_d   <= NOP_WORD;
            pc_d      <= IM_BASE;
            pc4_d     <= IM_BASE + 32'd4;
            valid_d   <= 1'b0;
            adel_d    <= 1'b0;
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            pc_d      <= pc_f;
            pc4_d     <= pc4_f;
            valid_d   <= !flush;
            adel_d    <= !flush && adel_f;
            instr_d   <= (flush || adel_f) ? NOP_WORD : instr_f;
            fetch_cnt <= flush ? fetch_cnt : fetch_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ifid_reg.sv
// tb_ifid_reg: directed vectors feed a scoreboard queue; a monitor compares D outputs each cycle
module tb_ifid_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_f = '0;
    logic [31:0] pc_f = '0;
    logic [31:0] pc4_f = '0;
    logic [31:0] instr_d, pc_d, pc4_d, fetch_cnt, stall_cnt;
    logic        valid_d, adel_d;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        adel;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    ifid_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .instr_f(instr_f), .pc_f(pc_f), .pc4_f(pc4_f),
        .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d),
        .valid_d(valid_d), .adel_d(adel_d),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, want);
    endtask

    // Monitor: every posedge presents a new D-stage snapshot; compare it against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("instr_d", instr_d, e.instr);
                chk("pc_d", pc_d, e.pc);
                chk("pc4_d", pc4_d, e.pc4);
                chk("valid_d", {31'b0, valid_d}, {31'b0, e.valid});
                chk("adel_d", {31'b0, adel_d}, {31'b0, e.adel});
                chk("fetch_cnt", fetch_cnt, e.fcnt);
                chk("stall_cnt", stall_cnt, e.scnt);
            end
        end
    end

    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] e_ins, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                        input logic e_v, input logic e_a, input logic [31:0] e_f, input logic [31:0] e_s);
        reset = rst; stall = st; flush = fl;
        instr_f = ins; pc_f = pc; pc4_f = pc4;
        q.push_back('{e_ins, e_pc, e_pc4, e_v, e_a, e_f, e_s});
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset with arbitrary inputs, stall/flush ignored
        step(0, 1, 1, 32'hDEADBEEF, 32'h00001234, 32'h00001238, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
        step(0, 0, 1, 32'hCAFEF00D, 32'h00003001, 32'h00003005, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
        // load stream
        step(1, 0, 0, 32'h24080001, 32'h3000, 32'h3004, 32'h24080001, 32'h3000, 32'h3004, 1, 0, 1, 0);
        step(1, 0, 0, 32'h24090002, 32'h3004, 32'h3008, 32'h24090002, 32'h3004, 32'h3008, 1, 0, 2, 0);
        step(1, 0, 0, 32'h01095020, 32'h3008, 32'h300C, 32'h01095020, 32'h3008, 32'h300C, 1, 0, 3, 0);
        step(1, 0, 0, 32'h24090002, 32'h3004, 32'h3008, 32'h24090002, 32'h3004, 32'h3008, 1, 0, 4, 0);
        // stall beats flush while F inputs change
        step(1, 1, 1, 32'hAAAA0001, 32'h5000, 32'h5004, 32'h24090002, 32'h3004, 32'h3008, 1, 0, 4, 1);
        step(1, 1, 1, 32'hAAAA0002, 32'h5004, 32'h5008, 32'h24090002, 32'h3004, 32'h3008, 1, 0, 4, 2);
        step(1, 1, 1, 32'hAAAA0003, 32'h3001, 32'h3005, 32'h24090002, 32'h3004, 32'h3008, 1, 0, 4, 3);
        // flush alone
        step(1, 0, 1, 32'h11111111, 32'h300C, 32'h3010, 32'h0, 32'h300C, 32'h3010, 0, 0, 4, 3);
        // address faults and the last legal word
        step(1, 0, 0, 32'hFFFFFFFF, 32'h3002, 32'h3006, 32'h0, 32'h3002, 32'h3006, 1, 1, 5, 3);
        step(1, 0, 0, 32'hFFFFFFFF, 32'h2FFC, 32'h3000, 32'h0, 32'h2FFC, 32'h3000, 1, 1, 6, 3);
        step(1, 0, 0, 32'hFFFFFFFF, 32'h7000, 32'h7004, 32'h0, 32'h7000, 32'h7004, 1, 1, 7, 3);
        step(1, 0, 0, 32'hFFFFFFFF, 32'h6FFC, 32'h7000, 32'hFFFFFFFF, 32'h6FFC, 32'h7000, 1, 0, 8, 3);
        step(1, 0, 0, 32'h12345678, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 1, 1, 9, 3);
        // flush right after a fault clears adel_d
        step(1, 0, 1, 32'h12345678, 32'h3010, 32'h3014, 32'h0, 32'h3010, 32'h3014, 0, 0, 9, 3);
        // counter wrap
        force dut.fetch_cnt = 32'hFFFFFFFF;
        #1;
        release dut.fetch_cnt;
        step(1, 0, 0, 32'h12345678, 32'h3010, 32'h3014, 32'h12345678, 32'h3010, 32'h3014, 1, 0, 0, 3);
        step(1, 1, 0, 32'h0, 32'h3014, 32'h3018, 32'h12345678, 32'h3010, 32'h3014, 1, 0, 0, 4);
        step(1, 1, 1, 32'h0, 32'h3018, 32'h301C, 32'h12345678, 32'h3010, 32'h3014, 1, 0, 0, 5);
        // reset in the middle of a stall
        step(0, 1, 1, 32'h87654321, 32'h4000, 32'h4004, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
        step(1, 0, 0, 32'h24080001, 32'h3000, 32'h3004, 32'h24080001, 32'h3000, 32'h3004, 1, 0, 1, 0);
        done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (done);
        while (q.size() != 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ifid_reg.md
# ifid_reg

Fetch/decode pipeline register for the five-stage MIPS core. It sits directly downstream of the PC stage and captures the fetched instruction together with its PC and PC+4 every cycle. It supports hazard stall (hold), branch/jump flush (bubble insertion) and instruction-address fault detection (AdEL). It also keeps two free-running 32-bit performance counters: instructions delivered to decode and stall cycles.

## Interface
Parameters:
- IM_BASE, 32'h00003000, byte address of the first instruction word; also the PC reset value.
- IM_WORDS, 4096, instruction memory depth in 32-bit words.
- NOP_WORD, 32'h00000000, encoding driven into decode for bubbles and faulted fetches.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on posedge clk.
- stall  in  1  hold request from the hazard unit; 1 = keep the current D-stage contents.
- flush  in  1  kill request from branch/jump resolution; 1 = insert a bubble.
- instr_f  in  32  instruction word read from IM at pc_f.
- pc_f  in  32  PC of the instruction being fetched.
- pc4_f  in  32  pc_f+4 from the PC stage.
- instr_d  out  32  registered instruction to decode.
- pc_d  out  32  registered PC.
- pc4_d  out  32  registered PC+4.
- valid_d  out  1  1 = instr_d is a real instruction; 0 = bubble.
- adel_d  out  1  1 = the instruction-address fault was detected on the captured fetch.
- fetch_cnt  out  32  count of valid instructions loaded into D.
- stall_cnt  out  32  count of cycles with stall=1 outside reset.

## Operation
- Fault check (combinational on F inputs): adel_f = (pc_f[1:0] != 0) OR (pc_f < IM_BASE) OR (pc_f >= IM_BASE + 4*IM_WORDS).
- Evaluate the upper-bound compare in 33 bits so that IM_BASE + 4*IM_WORDS cannot wrap.
- Per posedge, the priority order is reset > stall > flush > load.
- Reset (reset=0):
  - instr_d=NOP_WORD, pc_d=IM_BASE, pc4_d=IM_BASE+4.
  - valid_d=0, adel_d=0.
  - fetch_cnt=0, stall_cnt=0.
- Stall (stall=1):
  - All of instr_d, pc_d, pc4_d, valid_d and adel_d hold their values.
  - stall_cnt increments. fetch_cnt holds.
  - A flush asserted in the same cycle is ignored. The flush source must keep asserting it until stall drops.
- Flush (stall=0, flush=1):
  - instr_d=NOP_WORD, valid_d=0, adel_d=0.
  - pc_d and pc4_d load pc_f and pc4_f, for trace only.
  - Counters hold.
- Load (stall=0, flush=0):
  - pc_d=pc_f, pc4_d=pc4_f, valid_d=1, adel_d=adel_f.
  - instr_d = adel_f ? NOP_WORD : instr_f.
  - fetch_cnt increments, faulted fetches included.
- Both counters wrap modulo 2^32 with no saturation and no flag.
- There is no state machine beyond these registers. The block is a pure stage register plus counters.

## Timing
- Latency is 1 cycle: F inputs valid before posedge N appear on the D outputs after posedge N.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Stall for k consecutive cycles: the D outputs stay constant for k cycles and stall_cnt advances by k.
- Reset in the middle of a stall or flush: at the next posedge all outputs take their reset values regardless of stall/flush.
- First cycle after reset release: normal load. pc_d=IM_BASE if the PC stage presents IM_BASE.
- The PC stage owns the stall of PC itself. This block only holds D.

## Test plan
- Reset: hold reset=0 for 2 cycles with arbitrary inputs -> instr_d=0, pc_d=0x3000, pc4_d=0x3004, valid_d=0, adel_d=0, both counters 0.
- Load stream: release reset; drive pc_f=0x3000/0x3004/0x3008 with instr_f=0x24080001/0x24090002/0x01095020 and no stall/flush -> each appears one cycle later with valid_d=1 and adel_d=0; fetch_cnt=3.
- Stall priority: with D holding pc_d=0x3004, assert stall and flush together for 3 cycles while the F inputs change -> D is unchanged, stall_cnt=3, fetch_cnt unchanged. Then flush alone for 1 cycle -> instr_d=0, valid_d=0.
- Address fault: pc_f=0x3002, then pc_f=0x2FFC, then pc_f=0x7000 with instr_f=0xFFFFFFFF -> each gives adel_d=1, instr_d=0, valid_d=1. pc_f=0x6FFC -> adel_d=0.
- Counter wrap: force fetch_cnt to 0xFFFFFFFF, then perform one load -> fetch_cnt=0.
- Reset mid-operation: assert reset=0 during a stall with stall_cnt=5 -> all outputs return to their reset values on the next edge.
